// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  cpu_pkg
//  Shared widths and the writeback source enumeration for the CPU core.
//  Revision: 1.0
// ============================================================================
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 32;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_t;

endpackage
`default_nettype wire

// File: rtl/wb_scheduler_if.sv
`default_nettype none
// ============================================================================
//  wb_scheduler_if
//  Issue, writeback and register-file port bundle for wb_scheduler.
//  Revision: 1.0
// ============================================================================
interface wb_scheduler_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic             issue_valid;
    logic [AW-1:0]    issue_rd;
    logic [AW-1:0]    issue_rs1;
    logic [AW-1:0]    issue_rs2;
    logic             issue_ready;

    logic             alu_wb_valid;
    logic [AW-1:0]    alu_wb_rd;
    logic [XLEN-1:0]  alu_wb_data;
    logic             alu_wb_ready;

    logic             lsu_wb_valid;
    logic [AW-1:0]    lsu_wb_rd;
    logic [XLEN-1:0]  lsu_wb_data;
    logic             lsu_wb_ready;

    logic             rf_write_enable;
    logic [AW-1:0]    rf_write_reg;
    logic [XLEN-1:0]  rf_write_data;

    logic [NREGS-1:0] busy_vec;
    logic             wb_err;

    modport master (
        output issue_valid, issue_rd, issue_rs1, issue_rs2,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        input  issue_ready, alu_wb_ready, lsu_wb_ready,
        input  rf_write_enable, rf_write_reg, rf_write_data,
        input  busy_vec, wb_err
    );

    modport slave (
        input  issue_valid, issue_rd, issue_rs1, issue_rs2,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        output issue_ready, alu_wb_ready, lsu_wb_ready,
        output rf_write_enable, rf_write_reg, rf_write_data,
        output busy_vec, wb_err
    );

endinterface
`default_nettype wire

// File: rtl/wb_scheduler_rr_arb2.sv
`default_nettype none
// ============================================================================
//  rr_arb2
//  Two-way round-robin arbiter; the pointer only moves on contested cycles.
//  Revision: 1.0
// ============================================================================
module rr_arb2
    import cpu_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] i_req,
    output logic      [1:0] o_grant
);

    // Winner of the most recent contested cycle; resetting to LSU favours ALU next.
    wb_src_t r_last;
    logic    w_contested;

    assign w_contested = &i_req;

    always_comb begin
        o_grant = i_req;
        if (w_contested) begin
            o_grant = (r_last == WB_LSU) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= WB_LSU;
        end else if (w_contested) begin
            r_last <= o_grant[1] ? WB_LSU : WB_ALU;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_scheduler.sv
`default_nettype none
// ============================================================================
//  wb_scheduler
//  Register scoreboard, issue stall and ALU/LSU writeback arbitration.
//  Optional macro WB_SCHED_BYPASS_EN: same-cycle writeback un-stalls issue.
//  Revision: 1.0
// ============================================================================
module wb_scheduler
    import cpu_pkg::*;
#(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int NREGS = cpu_pkg::NREGS
) (
    input  wire logic     clk,
    input  wire logic     rst,
    wb_scheduler_if.slave bus
);

    localparam int AW = $clog2(NREGS);
    localparam logic [NREGS-1:0] c_ONE     = {{(NREGS-1){1'b0}}, 1'b1};
    localparam logic [NREGS-1:0] c_X0_MASK = ~c_ONE;

    logic [NREGS-1:0] r_busy;
    logic             r_err;

    logic [1:0]       w_grant;
    wb_src_t          w_src;
    logic             w_wb_fire;
    logic [AW-1:0]    w_wb_rd;
    logic [XLEN-1:0]  w_wb_data;
    logic             w_we;
    logic [NREGS-1:0] w_clr_vec;
    logic [NREGS-1:0] w_set_vec;
    logic [NREGS-1:0] w_eff_busy;
    logic             w_issue_ready;
    logic             w_issue_fire;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   ({bus.lsu_wb_valid, bus.alu_wb_valid}),
        .o_grant (w_grant)
    );

    assign w_src     = w_grant[1] ? WB_LSU : WB_ALU;
    assign w_wb_fire = |w_grant;
    assign w_wb_rd   = (w_src == WB_LSU) ? bus.lsu_wb_rd   : bus.alu_wb_rd;
    assign w_wb_data = (w_src == WB_LSU) ? bus.lsu_wb_data : bus.alu_wb_data;
    assign w_we      = w_wb_fire && (w_wb_rd != '0);
    assign w_clr_vec = w_we ? (c_ONE << w_wb_rd) : '0;

`ifdef WB_SCHED_BYPASS_EN
    assign w_eff_busy = r_busy & ~w_clr_vec;
`else
    assign w_eff_busy = r_busy;
`endif

    assign w_issue_ready = !w_eff_busy[bus.issue_rs1] &&
                           !w_eff_busy[bus.issue_rs2] &&
                           !w_eff_busy[bus.issue_rd];
    assign w_issue_fire  = bus.issue_valid && w_issue_ready;
    assign w_set_vec     = (w_issue_fire && (bus.issue_rd != '0)) ? (c_ONE << bus.issue_rd) : '0;

    // Set is applied after clear so a same-cycle issue to the written register wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= ((r_busy & ~w_clr_vec) | w_set_vec) & c_X0_MASK;
            if (w_we && !r_busy[w_wb_rd]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.issue_ready     = w_issue_ready;
    assign bus.alu_wb_ready    = w_grant[0];
    assign bus.lsu_wb_ready    = w_grant[1];
    assign bus.rf_write_enable = w_we;
    assign bus.rf_write_reg    = w_wb_rd;
    assign bus.rf_write_data   = w_wb_data;
    assign bus.busy_vec        = r_busy;
    assign bus.wb_err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  tb_wb_scheduler
//  Directed scenarios plus a randomized run against a set-based scoreboard model.
//  Revision: 1.0
// ============================================================================
module tb_wb_scheduler;

`ifdef WB_SCHED_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    // Reference model: set of registers awaiting a write, last contested winner, sticky error
    bit   mb[32];
    int   last_win;
    bit   merr;

    wb_scheduler_if #(.XLEN(32), .NREGS(32)) bus ();

    wb_scheduler #(.XLEN(32), .NREGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    function automatic logic [31:0] model_vec();
        logic [31:0] v;
        v = '0;
        for (int r = 0; r < 32; r++) v[r] = mb[r];
        return v;
    endfunction

    function automatic logic [4:0] pick_rd();
        logic [4:0] lst[$];
        for (int r = 1; r < 32; r++) if (mb[r]) lst.push_back(5'(r));
        if (lst.size() == 0 || $urandom_range(0, 5) == 0) return 5'd0;
        return lst[$urandom_range(0, lst.size() - 1)];
    endfunction

    task automatic clear_inputs();
        bus.issue_valid  = 1'b0; bus.issue_rd  = '0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
        bus.alu_wb_valid = 1'b0; bus.alu_wb_rd = '0; bus.alu_wb_data = '0;
        bus.lsu_wb_valid = 1'b0; bus.lsu_wb_rd = '0; bus.lsu_wb_data = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 32; r++) mb[r] = 1'b0;
        last_win = 1;
        merr = 1'b0;
    endtask

    task automatic issue_one(input logic [4:0] rd);
        @(negedge clk);
        bus.issue_valid = 1'b1; bus.issue_rd = rd; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        #1;
        n_checks++;
        if (bus.busy_vec !== 32'h0) begin
            $display("FAIL reset_busy: got %h expected %h", bus.busy_vec, 32'h0); n_errors++;
        end
        n_checks++;
        if (bus.wb_err !== 1'b0) begin
            $display("FAIL reset_err: got %b expected 0", bus.wb_err); n_errors++;
        end
        n_checks++;
        if (bus.issue_ready !== 1'b1) begin
            $display("FAIL reset_ready: got %b expected 1", bus.issue_ready); n_errors++;
        end
        apply_reset();
    endtask

    task automatic test_issue_raw();
        issue_one(5'd5);
        @(negedge clk);
        n_checks++;
        if (bus.busy_vec !== 32'h20) begin
            $display("FAIL issue_busy: got %h expected %h", bus.busy_vec, 32'h20); n_errors++;
        end
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd6; bus.issue_rs1 = 5'd5;
        #1;
        n_checks++;
        if (bus.issue_ready !== 1'b0) begin
            $display("FAIL raw_stall: got %b expected 0", bus.issue_ready); n_errors++;
        end
        bus.issue_valid = 1'b0;
    endtask

    task automatic test_writeback();
        @(negedge clk);
        bus.issue_valid  = 1'b0; bus.issue_rd = 5'd6; bus.issue_rs1 = 5'd5; bus.issue_rs2 = 5'd0;
        bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd5; bus.alu_wb_data = 32'hDEADBEEF;
        #1;
        n_checks++;
        if ({bus.alu_wb_ready, bus.rf_write_enable} !== 2'b11) begin
            $display("FAIL wb_grant: got %b expected 11", {bus.alu_wb_ready, bus.rf_write_enable}); n_errors++;
        end
        n_checks++;
        if (bus.rf_write_reg !== 5'd5 || bus.rf_write_data !== 32'hDEADBEEF) begin
            $display("FAIL wb_port: got reg %0d data %h expected reg 5 data deadbeef",
                     bus.rf_write_reg, bus.rf_write_data); n_errors++;
        end
        n_checks++;
        if (bus.issue_ready !== BYP) begin
            $display("FAIL wb_bypass_ready: got %b expected %b", bus.issue_ready, BYP); n_errors++;
        end
        @(negedge clk);
        bus.alu_wb_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.busy_vec !== 32'h0 || bus.issue_ready !== 1'b1) begin
            $display("FAIL wb_after: got busy %h ready %b expected busy 0 ready 1",
                     bus.busy_vec, bus.issue_ready); n_errors++;
        end
        clear_inputs();
    endtask

    task automatic contested_round(input logic lsu_first);
        logic [4:0] first_rd;
        issue_one(5'd3);
        issue_one(5'd4);
        @(negedge clk);
        bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd3; bus.alu_wb_data = 32'hA0A0_0003;
        bus.lsu_wb_valid = 1'b1; bus.lsu_wb_rd = 5'd4; bus.lsu_wb_data = 32'hB0B0_0004;
        first_rd = lsu_first ? 5'd4 : 5'd3;
        #1;
        n_checks++;
        if ({bus.lsu_wb_ready, bus.alu_wb_ready} !== (lsu_first ? 2'b10 : 2'b01) ||
            bus.rf_write_reg !== first_rd) begin
            $display("FAIL contest_first: got grant %b reg %0d expected lsu_first=%b reg %0d",
                     {bus.lsu_wb_ready, bus.alu_wb_ready}, bus.rf_write_reg, lsu_first, first_rd);
            n_errors++;
        end
        @(negedge clk);
        if (lsu_first) bus.lsu_wb_valid = 1'b0; else bus.alu_wb_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.lsu_wb_ready, bus.alu_wb_ready} !== (lsu_first ? 2'b01 : 2'b10) ||
            bus.rf_write_data !== (lsu_first ? 32'hA0A0_0003 : 32'hB0B0_0004)) begin
            $display("FAIL contest_second: got grant %b data %h",
                     {bus.lsu_wb_ready, bus.alu_wb_ready}, bus.rf_write_data); n_errors++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++;
        if (bus.busy_vec !== 32'h0 || bus.wb_err !== 1'b0) begin
            $display("FAIL contest_clear: got busy %h err %b expected 0 0", bus.busy_vec, bus.wb_err);
            n_errors++;
        end
    endtask

    task automatic test_back_to_back();
        contested_round(1'b0);
        contested_round(1'b1);
    endtask

    task automatic test_x0();
        @(negedge clk);
        bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd0; bus.alu_wb_data = 32'h1234_5678;
        #1;
        n_checks++;
        if (bus.alu_wb_ready !== 1'b1 || bus.rf_write_enable !== 1'b0) begin
            $display("FAIL x0_write: got ready %b we %b expected 1 0", bus.alu_wb_ready, bus.rf_write_enable);
            n_errors++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++;
        if (bus.wb_err !== 1'b0) begin
            $display("FAIL x0_err: got %b expected 0", bus.wb_err); n_errors++;
        end
    endtask

    task automatic test_random();
        logic ap, lp, ga, gl, we, iv, rdy;
        logic [4:0] ard, lrd, wreg, ird, rs1, rs2;
        logic [31:0] ad, ld, wdat;
        apply_reset();
        ap = 0; lp = 0; ard = 0; lrd = 0; ad = 0; ld = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (!ap && $urandom_range(0, 2) == 0) begin ap = 1; ard = pick_rd(); ad = $urandom; end
            if (!lp && $urandom_range(0, 2) == 0) begin lp = 1; lrd = pick_rd(); ld = $urandom; end
            iv  = 1'($urandom_range(0, 1));
            ird = 5'($urandom_range(0, 31));
            rs1 = 5'($urandom_range(0, 15));
            rs2 = 5'($urandom_range(0, 15));
            bus.alu_wb_valid = ap; bus.alu_wb_rd = ard; bus.alu_wb_data = ad;
            bus.lsu_wb_valid = lp; bus.lsu_wb_rd = lrd; bus.lsu_wb_data = ld;
            bus.issue_valid = iv; bus.issue_rd = ird; bus.issue_rs1 = rs1; bus.issue_rs2 = rs2;
            #1;
            ga   = ap && (!lp || last_win == 1);
            gl   = lp && (!ap || last_win == 0);
            wreg = ga ? ard : lrd;
            wdat = ga ? ad : ld;
            we   = (ga || gl) && (wreg != 0);
            rdy  = !(mb[rs1] && !(BYP && we && wreg == rs1)) &&
                   !(mb[rs2] && !(BYP && we && wreg == rs2)) &&
                   !(mb[ird] && !(BYP && we && wreg == ird));
            n_checks++;
            if (bus.busy_vec !== model_vec() || bus.wb_err !== merr) begin
                $display("FAIL rand_state c%0d: got busy %h err %b expected busy %h err %b",
                         c, bus.busy_vec, bus.wb_err, model_vec(), merr); n_errors++;
            end
            n_checks++;
            if ({bus.alu_wb_ready, bus.lsu_wb_ready, bus.rf_write_enable} !== {ga, gl, we}) begin
                $display("FAIL rand_grant c%0d: got %b expected %b", c,
                         {bus.alu_wb_ready, bus.lsu_wb_ready, bus.rf_write_enable}, {ga, gl, we});
                n_errors++;
            end
            if (ga || gl) begin
                n_checks++;
                if (bus.rf_write_reg !== wreg || bus.rf_write_data !== wdat) begin
                    $display("FAIL rand_port c%0d: got reg %0d data %h expected reg %0d data %h",
                             c, bus.rf_write_reg, bus.rf_write_data, wreg, wdat); n_errors++;
                end
            end
            n_checks++;
            if (bus.issue_ready !== rdy) begin
                $display("FAIL rand_ready c%0d: got %b expected %b", c, bus.issue_ready, rdy); n_errors++;
            end
            if (ap && lp) last_win = ga ? 0 : 1;
            if (we && !mb[wreg]) merr = 1'b1;
            if (we) mb[wreg] = 1'b0;
            if (iv && rdy && ird != 0) mb[ird] = 1'b1;
            if (ga) ap = 0;
            if (gl) lp = 0;
        end
        clear_inputs();
    endtask

    task automatic test_err();
        apply_reset();
        @(negedge clk);
        bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd7; bus.alu_wb_data = 32'h7;
        #1;
        n_checks++;
        if (bus.wb_err !== 1'b0) begin
            $display("FAIL err_early: got %b expected 0", bus.wb_err); n_errors++;
        end
        @(negedge clk);
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (bus.wb_err !== 1'b1) begin
                $display("FAIL err_sticky k%0d: got %b expected 1", k, bus.wb_err); n_errors++;
            end
            @(negedge clk);
        end
        apply_reset();
        #1;
        n_checks++;
        if (bus.wb_err !== 1'b0) begin
            $display("FAIL err_reset: got %b expected 0", bus.wb_err); n_errors++;
        end
    endtask

    task automatic test_async_reset();
        for (int r = 1; r < 32; r++) issue_one(5'(r));
        @(negedge clk);
        n_checks++;
        if (bus.busy_vec !== 32'hFFFF_FFFE) begin
            $display("FAIL full_busy: got %h expected fffffffe", bus.busy_vec); n_errors++;
        end
        bus.issue_rs1 = 5'd5;
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.busy_vec !== 32'h0 || bus.issue_ready !== 1'b1) begin
            $display("FAIL async_reset: got busy %h ready %b expected busy 0 ready 1",
                     bus.busy_vec, bus.issue_ready); n_errors++;
        end
        apply_reset();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_issue_raw();
        test_writeback();
        test_back_to_back();
        test_x0();
        test_random();
        test_err();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
